fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and drives the IF/ID register that feeds the decode stage. Consumes the decode stage's `nextPC`/`pcsrc` redirect outputs and the hazard unit's stall. It is the producer side of the decode stage's PC and instruction inputs.

---
 rtl/fetch_stage.sv | 182 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake, drives IF/ID.
// Optional misaligned-fetch trap is enabled by defining FETCH_ALIGN_CHECK_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_RST   | first cycle after reset release, no request
// S_FETCH | request pc, wait for ack
// S_HOLD  | word captured while stalled, no request until stall drops
// S_KILL  | flushed mid-fetch, finish the old request and discard its data
// S_AERR  | misaligned pc trapped, wait for an exception redirect
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic [1:0]  i_pcsrc,
  input  logic [31:0] i_nextPC,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_valid,
  output logic        o_addr_exc
);

  typedef enum logic [2:0] {S_RST, S_FETCH, S_HOLD, S_KILL, S_AERR} state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] pend_tgt, pend_tgt_d;
  logic        pend_v, pend_v_d;
  logic [31:0] hold_instr, hold_instr_d;
  logic [31:0] hold_pc, hold_pc_d;
  logic [31:0] kill_addr, kill_addr_d;
  logic [31:0] ifid_instr, ifid_instr_d;
  logic [31:0] ifid_pc, ifid_pc_d;
  logic        ifid_valid, ifid_valid_d;
  logic        exc, br, misalign;
  logic [31:0] pc_inc, seq_pc;

  assign exc    = i_pcsrc[1];
  assign br     = (i_pcsrc == 2'b01);
  assign pc_inc = pc + 32'd4;
  assign seq_pc = pend_v ? pend_tgt : pc_inc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic addr_exc, addr_exc_d;
  assign misalign   = (pc[1:0] != 2'b00);
  assign o_addr_exc = addr_exc;
`else
  assign misalign   = 1'b0;
  assign o_addr_exc = 1'b0;
`endif

  // S_KILL replays the abandoned address so the bus sees a stable request
  assign o_imem_req  = (state == S_KILL) || ((state == S_FETCH) && !misalign);
  assign o_imem_addr = (state == S_KILL) ? kill_addr : {pc[31:2], 2'b00};
  assign o_pc        = ifid_pc;
  assign o_instr     = ifid_instr;
  assign o_valid     = ifid_valid;

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    pend_tgt_d   = pend_tgt;
    pend_v_d     = pend_v;
    hold_instr_d = hold_instr;
    hold_pc_d    = hold_pc;
    kill_addr_d  = kill_addr;
    ifid_instr_d = ifid_instr;
    ifid_pc_d    = ifid_pc;
    ifid_valid_d = ifid_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    addr_exc_d   = 1'b0;
`endif
    if (state != S_RST && exc) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = 32'h0;
      pend_v_d     = 1'b0;
      pc_d         = i_nextPC;
    end
    case (state)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        if (exc) begin
          kill_addr_d = o_imem_addr;
          state_d     = (o_imem_req && !i_imem_ack) ? S_KILL : S_FETCH;
        end else if (misalign) begin
`ifdef FETCH_ALIGN_CHECK_EN
          addr_exc_d = 1'b1;
`endif
          if (!i_stall) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = 32'h0;
          end
          state_d = S_AERR;
        end else if (i_imem_ack) begin
          if (i_stall) begin
            hold_instr_d = i_imem_rdata;
            hold_pc_d    = pc_inc;
            state_d      = S_HOLD;
          end else begin
            ifid_instr_d = i_imem_rdata;
            ifid_pc_d    = pc_inc;
            ifid_valid_d = 1'b1;
            // a branch seen now has its delay slot in this very word
            pc_d         = br ? i_nextPC : seq_pc;
            pend_v_d     = 1'b0;
          end
        end else if (!i_stall) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = 32'h0;
          if (br) begin
            pend_tgt_d = i_nextPC;
            pend_v_d   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (exc) begin
          state_d = S_FETCH;
        end else if (!i_stall) begin
          ifid_instr_d = hold_instr;
          ifid_pc_d    = hold_pc;
          ifid_valid_d = 1'b1;
          pc_d         = br ? i_nextPC : seq_pc;
          pend_v_d     = 1'b0;
          state_d      = S_FETCH;
        end
      end
      S_KILL: begin
        if (i_imem_ack) state_d = S_FETCH;
      end
      S_AERR: begin
        if (exc) begin
          state_d = S_FETCH;
        end else if (!i_stall) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = 32'h0;
        end
      end
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_RST;
      pc         <= RESET_VECTOR;
      pend_tgt   <= 32'h0;
      pend_v     <= 1'b0;
      hold_instr <= 32'h0;
      hold_pc    <= 32'h0;
      kill_addr  <= 32'h0;
      ifid_instr <= 32'h0;
      ifid_pc    <= 32'h0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      pend_tgt   <= pend_tgt_d;
      pend_v     <= pend_v_d;
      hold_instr <= hold_instr_d;
      hold_pc    <= hold_pc_d;
      kill_addr  <= kill_addr_d;
      ifid_instr <= ifid_instr_d;
      ifid_pc    <= ifid_pc_d;
      ifid_valid <= ifid_valid_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) addr_exc <= 1'b0;
    else          addr_exc <= addr_exc_d;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory responder, IF/ID scoreboard, step-by-step checks.
module tb_fetch_stage;

  logic        clk, rst_n, stall;
  logic [1:0]  pcsrc;
  logic [31:0] next_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] pc_out, instr_out;
  logic        valid_out, addr_exc;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   nerr = 0;
  int   nchk = 0;
  int   mem_lat = 1;
  int   exc_cnt, req_cnt;

  fetch_stage #(.RESET_VECTOR(32'h0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_pcsrc(pcsrc), .i_nextPC(next_pc),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack),
    .i_imem_rdata(imem_rdata), .o_pc(pc_out), .o_instr(instr_out), .o_valid(valid_out),
    .o_addr_exc(addr_exc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] a);
    exp_t e;
    e.instr = a;
    e.pc    = a + 32'd4;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a, input int max);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      step();
      if (imem_req && imem_addr == a) found = 1'b1;
    end
    chk(tag, {31'b0, found}, 32'd1);
  endtask

  // memory returns the address as data, acking on the mem_lat-th cycle of a request
  initial begin
    int cnt;
    cnt = 0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (cnt >= mem_lat - 1) begin
          imem_ack = 1'b1;
          imem_rdata = imem_addr;
          cnt = 0;
        end else begin
          imem_ack = 1'b0;
          cnt++;
        end
      end else begin
        imem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // decode consumes IF/ID on every edge where it is valid and not stalled
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && valid_out && !stall) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", instr_out, 32'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          chk("sb_instr", instr_out, e.instr);
          chk("sb_pc", pc_out, e.pc);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    pcsrc = 2'b00;
    next_pc = 32'h0;
    repeat (3) step();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instr_out, 32'h0);
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_exc", {31'b0, addr_exc}, 32'd0);

    // reset and run, zero-wait memory
    rst_n = 1'b1;
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    step();
    chk("run_req", {31'b0, imem_req}, 32'd1);
    chk("run_valid0", {31'b0, valid_out}, 32'd0);
    step();
    chk("run_valid1", {31'b0, valid_out}, 32'd1);
    chk("run_instr0", instr_out, 32'h0);
    chk("run_pc0", pc_out, 32'h4);
    chk("run_addr4", imem_addr, 32'h4);
    wait_req("wait_10", 32'h10, 10);

    // stall while a 3-cycle fetch of 0x10 completes
    mem_lat = 3;
    stall = 1'b1;
    step(); step(); step();
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_ifid", instr_out, 32'hC);
    step();
    chk("hold_req2", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    push(32'h10); push(32'h14); push(32'h18); push(32'h1C); push(32'h20);
    step();
    chk("unhold_instr", instr_out, 32'h10);
    chk("unhold_pc", pc_out, 32'h14);
    chk("unhold_addr", imem_addr, 32'h14);
    chk("unhold_req", {31'b0, imem_req}, 32'd1);

    // branch while 0x20 is outstanding: 0x20 is the delay slot
    wait_req("wait_20", 32'h20, 30);
    pcsrc = 2'b01;
    next_pc = 32'h100;
    step();
    pcsrc = 2'b00;
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_addr != 32'h20) break;
      step();
    end
    chk("br_addr", imem_addr, 32'h100);
    chk("br_ds_instr", instr_out, 32'h20);
    chk("br_ds_pc", pc_out, 32'h24);
    chk("br_ds_valid", {31'b0, valid_out}, 32'd1);

    // exception kill without stall during fetch of 0x40
    push(32'h100);
    pcsrc = 2'b01;
    next_pc = 32'h40;
    step();
    pcsrc = 2'b00;
    wait_req("wait_40a", 32'h40, 10);
    pcsrc = 2'b10;
    next_pc = 32'h180;
    step();
    pcsrc = 2'b00;
    chk("kill_req", {31'b0, imem_req}, 32'd1);
    chk("kill_addr", imem_addr, 32'h40);
    chk("kill_valid", {31'b0, valid_out}, 32'd0);
    wait_req("wait_180a", 32'h180, 10);
    chk("kill_instr", instr_out, 32'h0);

    // exception kill with stall, IF/ID holding a valid word
    pcsrc = 2'b01;
    next_pc = 32'h40;
    step();
    pcsrc = 2'b00;
    wait_req("wait_40b", 32'h40, 10);
    chk("skill_pre", instr_out, 32'h180);
    stall = 1'b1;
    pcsrc = 2'b10;
    next_pc = 32'h180;
    step();
    pcsrc = 2'b00;
    chk("skill_valid", {31'b0, valid_out}, 32'd0);
    chk("skill_instr", instr_out, 32'h0);
    chk("skill_addr", imem_addr, 32'h40);
    wait_req("wait_180b", 32'h180, 10);
    chk("skill_valid2", {31'b0, valid_out}, 32'd0);

    // simultaneous ack and flush, then PC wrap
    stall = 1'b0;
    mem_lat = 1;
    push(32'h180);
    step();
    chk("post_instr", instr_out, 32'h180);
    chk("post_addr", imem_addr, 32'h184);
    pcsrc = 2'b10;
    next_pc = 32'hFFFF_FFF8;
    push(32'hFFFF_FFF8); push(32'hFFFF_FFFC);
    step();
    pcsrc = 2'b00;
    chk("sim_valid", {31'b0, valid_out}, 32'd0);
    chk("sim_addr", imem_addr, 32'hFFFF_FFF8);
    step();
    chk("wrap_pc0", pc_out, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc1", pc_out, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    pcsrc = 2'b01;
    next_pc = 32'h102;
    push(32'h0);
    step();
    pcsrc = 2'b00;
    chk("align_ds", instr_out, 32'h0);
    exc_cnt = 0;
    req_cnt = 0;
    repeat (6) begin
      step();
      if (addr_exc) exc_cnt++;
      if (imem_req) req_cnt++;
    end
    chk("align_exc_pulses", exc_cnt, 1);
    chk("align_req_cycles", req_cnt, 0);
    pcsrc = 2'b10;
    next_pc = 32'h180;
    push(32'h180);
    step();
    pcsrc = 2'b00;
    chk("align_resume", imem_addr, 32'h180);
    chk("align_resume_req", {31'b0, imem_req}, 32'd1);
    step();
    chk("align_instr", instr_out, 32'h180);
`endif

    // asynchronous reset in the middle of a request
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_pc", pc_out, 32'h0);
    chk("arst_instr", instr_out, 32'h0);
    chk("arst_valid", {31'b0, valid_out}, 32'd0);
    chk("arst_exc", {31'b0, addr_exc}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    push(32'h0);
    step();
    chk("rerun_req", {31'b0, imem_req}, 32'd1);
    chk("rerun_addr", imem_addr, 32'h0);
    step();
    chk("rerun_instr", instr_out, 32'h0);
    chk("rerun_valid", {31'b0, valid_out}, 32'd1);
    #3;
    stall = 1'b1;
    step();
    step();
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
